mul_shift_add_64: RTL and testbench
===================================

Name: mul_shift_add_64

Overview:
Sequential unsigned radix-2 shift-and-add multiplier. It produces the full 128-bit product of two 64-bit operands for the n-th-root datapath, which needs x^n and mantissa-product terms.
- One 128-bit add per cycle, built from the team's ripple full-adder chain, cin tied 0.
- Latency is fixed and independent of the data.
- Start/done handshake toward the root-iteration controller.

Parameters:
WIDTH, 64, operand width in bits; product width is 2*WIDTH (128 at default).
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when state is IDLE
a  input  WIDTH  multiplicand, unsigned; captured on the accepted start edge
b  input  WIDTH  multiplier, unsigned; captured on the accepted start edge
busy  output  1  high in RUN and DONE states
done  output  1  single-cycle pulse, high in DONE state
product  output  2*WIDTH  last completed product; held until the next completion

Behaviour:
- Reset, asserted asynchronously while rst_n=0:
  - state=IDLE; acc, mcand, mplier, count, product all 0; busy=0, done=0.
  - Reset mid-operation aborts the multiply with no done pulse.
  - Release of reset has no side effect other than resuming at IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1, capture mcand={WIDTH'0,a}, mplier=b, acc=0, count=0, then go to RUN.
  - start=0: remain in IDLE.
- RUN, once per edge:
  - If mplier[0]=1, acc<=acc+mcand (2*WIDTH-bit add, carry-out discarded; the sum cannot exceed 2*WIDTH bits).
  - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - When count==WIDTH-1 this edge is the last iteration: go to DONE, and the final sum loads the product register on the same edge.
- DONE: lasts exactly one cycle with done=1, then goes to IDLE.
- Latency: start sampled at edge E0.
  - RUN occupies edges E1..E_WIDTH.
  - done=1 and the new product are visible in the cycle after E_WIDTH, i.e. WIDTH+1 edges after E0 (65 at default).
  - Fixed: no early termination, even when mplier becomes 0.
- start while busy=1, in RUN or DONE, is ignored. Operands must be re-presented in IDLE.
- Back-to-back operation: the earliest next acceptance is the edge following the DONE cycle, so throughput is one product per WIDTH+2 cycles.
- product changes only at the completion edge. It is never updated with partial sums; during RUN it holds the previous result.
- Operand changes on a/b after capture have no effect.
- Width rules:
  - All arithmetic is unsigned.
  - mcand shifts out of the top after at most WIDTH-1 shifts, which never loses set bits, since a occupies the low WIDTH bits.
  - count wraps are unreachable.

Test Plan:
- a=3, b=5, start 1 cycle -> busy rises next cycle; done=1 exactly 65 edges after start; product=15; done low the following cycle.
- a=0xFFFF_FFFF_FFFF_FFFF, b=same -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 at done.
- a=0x1234_5678_9ABC_DEF0, b=0 (and swapped) -> product=0, latency still 65; previous product held through RUN.
- Start a=7,b=9; at cycle 20 pulse start with a=2,b=2 -> ignored, done at cycle 65 with product=63; no second done.
- Start a=11,b=13; drop rst_n at cycle 30 (between edges) -> busy/done/product go 0 immediately; no done after release; next start a=2,b=3 yields product=6.
- Back-to-back: hold start=1 continuously with a=2^63,b=2 -> product=2^64 on each done, done pulses spaced 66 cycles apart.

Source files
------------

// File: rtl/mul_shift_add_64.sv
// Sequential unsigned radix-2 shift-and-add multiplier: full 2*WIDTH-bit product
// of two WIDTH-bit operands, fixed WIDTH+1 cycle latency, start/done handshake.

module mul_shift_add_64_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// Ripple-carry adder; the top stage produces only a sum bit because the carry-out
// is discarded by every user of this adder.
module mul_shift_add_64_rca #(
  parameter int W = 128
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s
);
  logic [W-1:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W - 1; i++) begin : g_fa
    mul_shift_add_64_fa u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign s[W-1] = x[W-1] ^ y[W-1] ^ c[W-1];
endmodule

// Handshake: start is honoured only in IDLE, on the rising edge where it is high.
// busy is high in RUN and DONE; done is a one-cycle pulse in DONE, at which point
// product already holds the new result. product is otherwise held.
module mul_shift_add_64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   sum;
  logic                 last_iter;

  assign addend    = mplier[0] ? mcand : '0;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  mul_shift_add_64_rca #(.W(2 * WIDTH)) u_add (
    .x  (acc),
    .y  (addend),
    .ci (1'b0),
    .s  (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // No early exit when mplier runs out of ones: latency stays data-independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (last_iter) product <= sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_shift_add_64.sv
// Directed bench for mul_shift_add_64: latency, product values, hold behaviour,
// ignored start while busy, asynchronous abort and back-to-back throughput.

module tb_mul_shift_add_64;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         busy;
  logic         done;
  logic [127:0] product;

  logic [127:0] exp_q[$];
  logic [127:0] last_prod;
  int           n_checks;
  int           n_errors;

  mul_shift_add_64 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One multiply; returns after checking done, product and the following cycle.
  task automatic run_mul(input logic [63:0] ai, input logic [63:0] bi,
                         input logic [127:0] exp_p, input int glitch_at);
    int           edges;
    bit           seen;
    logic [127:0] exp_v;
    exp_q.push_back(exp_p);
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    check_val("busy_rise", 128'(busy), 128'(1));
    check_val("hold_first", product, last_prod);
    seen = 1'b0;
    while (!seen && edges < 200) begin
      if (glitch_at != 0 && edges == glitch_at) begin
        a = 64'd2;
        b = 64'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 32) check_val("hold_mid", product, last_prod);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_val("latency", 128'(edges), 128'(65));
    exp_v = exp_q.pop_front();
    check_val("product", product, exp_v);
    last_prod = exp_v;
    @(negedge clk);
    check_val("done_low", 128'(done), 128'(0));
    check_val("busy_low", 128'(busy), 128'(0));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int           n_done;
    int           edges;
    int           done_edge[$];
    logic [127:0] p64;

    n_checks  = 0;
    n_errors  = 0;
    last_prod = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_product", product, 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", 128'(busy), 128'(0));

    run_mul(64'd3, 64'd5, 128'd15, 0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);
    run_mul(64'h1234_5678_9ABC_DEF0, 64'd0, 128'd0, 0);
    run_mul(64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0, 0);
    run_mul(64'h1234_5678_9ABC_DEF0, 64'h10, 128'h1_2345_6789_ABCD_EF00, 0);
    run_mul(64'hDEAD_BEEF, 64'h1_0000_0001, 128'hDEAD_BEEF_DEAD_BEEF, 0);

    // Start pulse mid-RUN must be ignored and produce no second done.
    run_mul(64'd7, 64'd9, 128'd63, 20);
    count_dones(70, n_done);
    check_val("no_extra_done", 128'(n_done), 128'(0));

    // Asynchronous abort between clock edges.
    @(negedge clk);
    a = 64'd11;
    b = 64'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_busy", 128'(busy), 128'(0));
    check_val("abort_done", 128'(done), 128'(0));
    check_val("abort_product", product, 128'(0));
    last_prod = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones(80, n_done);
    check_val("abort_no_done", 128'(n_done), 128'(0));
    check_val("abort_idle", 128'(busy), 128'(0));
    run_mul(64'd2, 64'd3, 128'd6, 0);

    // Back-to-back with start held high.
    p64 = 128'd1;
    p64 = p64 << 64;
    @(negedge clk);
    a = 64'h8000_0000_0000_0000;
    b = 64'd2;
    start = 1'b1;
    edges = 0;
    while (done_edge.size() < 3 && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        done_edge.push_back(edges);
        check_val("b2b_product", product, p64);
      end
    end
    start = 1'b0;
    check_val("b2b_count", 128'(done_edge.size()), 128'(3));
    if (done_edge.size() == 3) begin
      check_val("b2b_gap1", 128'(done_edge[1] - done_edge[0]), 128'(66));
      check_val("b2b_gap2", 128'(done_edge[2] - done_edge[1]), 128'(66));
    end
    repeat (80) @(negedge clk);
    check_val("final_idle", 128'(busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
